// File: rtl/tensor_output_packer.sv
// ---------------------------------------------------------------------------
// tensor_output_packer
//   Requantizes three signed 32-bit accumulator results per accepted beat to
//   saturated int8 and packs the bytes densely into 80-bit words of ten int8
//   lanes. Completed words are queued in a small output FIFO behind a
//   valid/ready handshake.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, clears all state
//   in_valid   : res0..res2 carry a valid beat
//   in_ready   : beat accepted on a rising edge with in_valid && in_ready
//   res0..res2 : signed accumulator results, lanes 0..2
//   in_last    : final beat of a tile, flushes any partial word
//   cfg_shift  : arithmetic right shift 0..31 (round half up)
//   cfg_relu   : clamp negative results to zero
//   out_valid  : FIFO head is valid
//   out_ready  : consumer takes the head with out_valid && out_ready
//   out_data   : byte k = int8 lane k
//   out_count  : number of valid bytes (1..10), unused bytes are zero
//   out_last   : last word of the tile
// ---------------------------------------------------------------------------
module tensor_output_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] res0,
    input  logic [31:0] res1,
    input  logic [31:0] res2,
    input  logic        in_last,
    input  logic [4:0]  cfg_shift,
    input  logic        cfg_relu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] out_data,
    output logic [3:0]  out_count,
    output logic        out_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    // Round-half-up shift, saturate to int8, optional ReLU.
    function automatic logic [7:0] requant(input logic [31:0] v,
                                           input logic [4:0]  sh,
                                           input logic        relu);
        logic signed [32:0] x;
        logic signed [32:0] rnd;
        logic [7:0]         r;
        x   = {v[31], v};
        rnd = 33'sd0;
        if (sh != 5'd0) begin
            rnd = 33'sd1 <<< (sh - 5'd1);
            x   = (x + rnd) >>> sh;
        end else begin
            x   = x;
        end
        if (x > 33'sd127) begin
            r = 8'h7F;
        end else if (x < -33'sd128) begin
            r = 8'h80;
        end else begin
            r = x[7:0];
        end
        if (relu && r[7]) begin
            r = 8'h00;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Circular pointer increment for a possibly non-power-of-two depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Packer state. Bytes at positions >= r_fill in r_pbuf are kept zero,
    // which lets new lanes be OR-ed in and partial words go out unmasked.
    logic [79:0]   r_pbuf;
    logic [3:0]    r_fill;

    // FIFO storage and bookkeeping
    logic [79:0]   r_mem_data  [FIFO_DEPTH];
    logic [3:0]    r_mem_count [FIFO_DEPTH];
    logic          r_mem_last  [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [OW-1:0] r_occ;

    // Registered outputs
    logic          r_in_ready;
    logic          r_out_valid;
    logic [79:0]   r_out_data;
    logic [3:0]    r_out_count;
    logic          r_out_last;

    logic          w_accept;
    logic          w_pop;
    logic [23:0]   w_lanes;
    logic [103:0]  w_ext;
    logic [3:0]    w_total;
    logic          w_full;
    logic [79:0]   w_rem_buf;
    logic [3:0]    w_rem_fill;
    logic [79:0]   w_nxt_pbuf;
    logic [3:0]    w_nxt_fill;
    logic          w_push0;
    logic          w_push1;
    logic [79:0]   w_e0_data;
    logic [3:0]    w_e0_count;
    logic          w_e0_last;
    logic [79:0]   w_e1_data;
    logic [3:0]    w_e1_count;
    logic          w_e1_last;
    logic [1:0]    w_npush;
    logic [OW-1:0] w_occ_nxt;
    logic [PW-1:0] w_wr1;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [79:0]   w_head_data;
    logic [3:0]    w_head_count;
    logic          w_head_last;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

    // Requantize the beat, append it to the pack buffer and decide what to push.
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_lanes    = {requant(res2, cfg_shift, cfg_relu),
                      requant(res1, cfg_shift, cfg_relu),
                      requant(res0, cfg_shift, cfg_relu)};
        // 13-byte staging: up to 9 buffered bytes plus 3 new ones
        w_ext      = {24'd0, r_pbuf} | ({80'd0, w_lanes} << {r_fill, 3'b000});
        w_total    = r_fill + 4'd3;
        w_full     = (w_total >= 4'd10);
        if (w_full) begin
            w_rem_buf  = {56'd0, w_ext[103:80]};
            w_rem_fill = w_total - 4'd10;
        end else begin
            w_rem_buf  = w_ext[79:0];
            w_rem_fill = w_total;
        end

        w_nxt_pbuf = r_pbuf;
        w_nxt_fill = r_fill;
        w_push0    = 1'b0;
        w_push1    = 1'b0;
        w_e0_data  = 80'd0;
        w_e0_count = 4'd0;
        w_e0_last  = 1'b0;
        w_e1_data  = 80'd0;
        w_e1_count = 4'd0;
        w_e1_last  = 1'b0;

        if (w_accept) begin
            w_nxt_pbuf = w_rem_buf;
            w_nxt_fill = w_rem_fill;
            if (w_full) begin
                w_push0    = 1'b1;
                w_e0_data  = w_ext[79:0];
                w_e0_count = 4'd10;
                // A tile ending exactly on a word boundary marks the full word last
                w_e0_last  = in_last && (w_rem_fill == 4'd0);
            end else begin
                w_push0    = 1'b0;
            end
            if (in_last && (w_rem_fill != 4'd0)) begin
                // Partial flush goes behind the full word if one was produced
                if (w_full) begin
                    w_push1    = 1'b1;
                    w_e1_data  = w_rem_buf;
                    w_e1_count = w_rem_fill;
                    w_e1_last  = 1'b1;
                end else begin
                    w_push0    = 1'b1;
                    w_e0_data  = w_rem_buf;
                    w_e0_count = w_rem_fill;
                    w_e0_last  = 1'b1;
                end
                w_nxt_pbuf = 80'd0;
                w_nxt_fill = 4'd0;
            end else begin
                w_push1    = 1'b0;
            end
        end else begin
            w_push0    = 1'b0;
        end
    end

    // FIFO next-state: pointers, occupancy and the entry that will be at the head.
    always_comb begin
        w_pop     = r_out_valid && out_ready;
        w_npush   = {1'b0, w_push0} + {1'b0, w_push1};
        w_occ_nxt = r_occ + OW'(w_npush) - OW'(w_pop);
        w_wr1     = ptr_inc(r_wr_ptr);
        if (w_push1) begin
            w_wr_nxt = ptr_inc(w_wr1);
        end else if (w_push0) begin
            w_wr_nxt = w_wr1;
        end else begin
            w_wr_nxt = r_wr_ptr;
        end
        w_rd_nxt  = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        // The head slot can only coincide with a write slot when nothing else
        // remains queued, and then it is always the first pushed entry.
        if (w_push0 && (r_wr_ptr == w_rd_nxt)) begin
            w_head_data  = w_e0_data;
            w_head_count = w_e0_count;
            w_head_last  = w_e0_last;
        end else begin
            w_head_data  = r_mem_data[w_rd_nxt];
            w_head_count = r_mem_count[w_rd_nxt];
            w_head_last  = r_mem_last[w_rd_nxt];
        end
    end

    // Packer, FIFO control and registered output state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pbuf      <= 80'd0;
            r_fill      <= 4'd0;
            r_rd_ptr    <= {PW{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_occ       <= {OW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 80'd0;
            r_out_count <= 4'd0;
            r_out_last  <= 1'b0;
        end else begin
            r_pbuf      <= w_nxt_pbuf;
            r_fill      <= w_nxt_fill;
            r_rd_ptr    <= w_rd_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_occ       <= w_occ_nxt;
            r_in_ready  <= (w_occ_nxt <= OW'(FIFO_DEPTH - 2));
            r_out_valid <= (w_occ_nxt != {OW{1'b0}});
            // Outputs keep their last values once the FIFO drains
            if (w_occ_nxt != {OW{1'b0}}) begin
                r_out_data  <= w_head_data;
                r_out_count <= w_head_count;
                r_out_last  <= w_head_last;
            end else begin
                r_out_data  <= r_out_data;
                r_out_count <= r_out_count;
                r_out_last  <= r_out_last;
            end
        end
    end

    // FIFO entry storage writes (one or two entries per cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= 80'd0;
                r_mem_count[i] <= 4'd0;
                r_mem_last[i]  <= 1'b0;
            end
        end else begin
            if (w_push0) begin
                r_mem_data[r_wr_ptr]  <= w_e0_data;
                r_mem_count[r_wr_ptr] <= w_e0_count;
                r_mem_last[r_wr_ptr]  <= w_e0_last;
            end else begin
                r_mem_data[r_wr_ptr]  <= r_mem_data[r_wr_ptr];
            end
            if (w_push1) begin
                r_mem_data[w_wr1]  <= w_e1_data;
                r_mem_count[w_wr1] <= w_e1_count;
                r_mem_last[w_wr1]  <= w_e1_last;
            end else begin
                r_mem_data[w_wr1]  <= r_mem_data[w_wr1];
            end
        end
    end

endmodule

// File: tb/tb_tensor_output_packer.sv
module tb_tensor_output_packer;

    typedef struct {
        logic [79:0] d;
        logic [3:0]  c;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res0, res1, res2;
    logic        in_last;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] out_data;
    logic [3:0]  out_count;
    logic        out_last;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;     // 0: hold low, 1: hold high, 2: random

    word_t exp_q[$];
    logic [7:0] pend[$];

    tensor_output_packer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .res0(res0), .res1(res1), .res2(res2),
        .in_last(in_last), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Consumer ready generator
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = (ready_mode == 1);
        end
    end

    // Reference requantization: round half up, floor shift, clamp, relu
    function automatic logic [7:0] ref_q(input logic [31:0] v, input int sh, input bit relu);
        longint x;
        x = longint'($signed(v));
        if (sh > 0) x = (x + (longint'(1) << (sh - 1))) >>> sh;
        if (x > 127)  x = 127;
        if (x < -128) x = -128;
        if (relu && x < 0) x = 0;
        return 8'(x);
    endfunction

    // Reference packer: a byte stream cut into 10-byte words
    task automatic model_beat(input logic [31:0] a, b, c, input bit last, input int sh, input bit relu);
        word_t w;
        word_t loc[$];
        pend.push_back(ref_q(a, sh, relu));
        pend.push_back(ref_q(b, sh, relu));
        pend.push_back(ref_q(c, sh, relu));
        while (pend.size() >= 10) begin
            w.d = 80'd0;
            for (int k = 0; k < 10; k++) w.d[8*k +: 8] = pend.pop_front();
            w.c = 4'd10;
            w.l = 1'b0;
            loc.push_back(w);
        end
        if (last) begin
            if (pend.size() > 0) begin
                w.d = 80'd0;
                w.c = 4'(pend.size());
                for (int k = 0; k < 10 && pend.size() > 0; k++) w.d[8*k +: 8] = pend.pop_front();
                w.l = 1'b1;
                loc.push_back(w);
            end else if (loc.size() > 0) begin
                loc[loc.size() - 1].l = 1'b1;
            end
        end
        foreach (loc[i]) exp_q.push_back(loc[i]);
    endtask

    task automatic push_exp(input logic [79:0] d, input logic [3:0] c, input logic l);
        word_t w;
        w.d = d; w.c = c; w.l = l;
        exp_q.push_back(w);
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one beat; called at posedge+1, returns at posedge+1 after acceptance
    task automatic send(input logic [31:0] a, b, c, input bit last, input int sh,
                        input bit relu, input bit mdl);
        int n;
        bit ok;
        in_valid = 1'b1; res0 = a; res1 = b; res2 = c;
        in_last = last; cfg_shift = 5'(sh); cfg_relu = relu;
        n = 0; ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else if (mdl) begin
            model_beat(a, b, c, last, sh, relu);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  80'(in_ready),  80'd1);
        chk({tag, "_out_valid"}, 80'(out_valid), 80'd0);
        chk({tag, "_out_data"},  out_data,       80'd0);
        chk({tag, "_out_count"}, 80'(out_count), 80'd0);
        chk({tag, "_out_last"},  80'(out_last),  80'd0);
    endtask

    // Monitor: scoreboard pop on handshake, stability while stalled
    initial begin
        word_t e;
        bit stall_prev;
        logic [79:0] hd;
        logic [3:0] hc;
        logic hl;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!out_valid || out_data !== hd || out_count !== hc || out_last !== hl) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h c=%0d l=%b held d=%h c=%0d l=%b",
                                 out_valid, out_data, out_count, out_last, hd, hc, hl);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL word: got d=%h c=%0d l=%b expected no word", out_data, out_count, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.d || out_count !== e.c || out_last !== e.l) begin
                            errors++;
                            $display("FAIL word: got d=%h c=%0d l=%b expected d=%h c=%0d l=%b",
                                     out_data, out_count, out_last, e.d, e.c, e.l);
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                hd = out_data; hc = out_count; hl = out_last;
            end
        end
    end

    initial begin
        logic [79:0] d;
        logic [31:0] v[3];
        int sh;
        int n;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        res0 = 32'd0; res1 = 32'd0; res2 = 32'd0;
        cfg_shift = 5'd0; cfg_relu = 1'b0;
        #3;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ready_mode = 1;
        idle(2);

        // Rounding and saturation
        push_exp(80'h01F808, 4'd3, 1'b1);
        send(32'd1000, -32'sd1000, 32'd64, 1'b1, 7, 1'b0, 1'b0);
        push_exp(80'h7F807F, 4'd3, 1'b1);
        send(32'd200, -32'sd200, 32'd127, 1'b1, 0, 1'b0, 1'b0);
        push_exp(80'h7F007F, 4'd3, 1'b1);
        send(32'd200, -32'sd200, 32'd127, 1'b1, 0, 1'b1, 1'b0);
        push_exp(80'h00FF01, 4'd3, 1'b1);
        send(32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1, 31, 1'b0, 1'b0);
        idle(4);

        // Packing 0..29, words visible after beats 4, 7 and 10
        for (int w = 0; w < 3; w++) begin
            d = 80'd0;
            for (int k = 0; k < 10; k++) d[8*k +: 8] = 8'(10*w + k);
            push_exp(d, 4'd10, (w == 2));
        end
        for (int i = 0; i < 10; i++) begin
            send(32'(3*i), 32'(3*i+1), 32'(3*i+2), (i == 9), 0, 1'b0, 1'b0);
            chk($sformatf("pack_valid_beat%0d", i + 1), 80'(out_valid),
                80'((i == 3) || (i == 6) || (i == 9)));
        end
        idle(4);

        // Double push: fill 9 then last
        d = 80'd0;
        for (int k = 0; k < 10; k++) d[8*k +: 8] = 8'(k + 1);
        push_exp(d, 4'd10, 1'b0);
        push_exp(80'h0C0B, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++)
            send(32'(3*i+1), 32'(3*i+2), 32'(3*i+3), (i == 3), 0, 1'b0, 1'b0);
        idle(4);

        // Backpressure with model-driven stimulus
        ready_mode = 0;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            send($urandom, $urandom, $urandom, 1'b0, 24, 1'b0, 1'b1);
            if (i == 8) chk("bp_ready_occ2", 80'(in_ready), 80'd1);
            if (i == 9) chk("bp_ready_occ3", 80'(in_ready), 80'd0);
        end
        idle(3);
        chk("bp_still_blocked", 80'(in_ready), 80'd0);
        ready_mode = 1;
        send(32'd5, -32'sd5, 32'd50, 1'b1, 0, 1'b0, 1'b1);
        idle(8);

        // Reset mid-stream with two queued words and fill 5
        ready_mode = 0;
        idle(2);
        send(32'd9, 32'd8, 32'd7, 1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(32'(i), 32'(i+1), 32'(i+2), 1'b0, 0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        exp_q.delete();
        pend.delete();
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        idle(1);
        push_exp(80'h030201, 4'd3, 1'b1);
        send(32'd1, 32'd2, 32'd3, 1'b1, 0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic against the reference model
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 3; j++) begin
                case ($urandom_range(0, 2))
                    0:       v[j] = 32'($signed($urandom_range(0, 600)) - 300);
                    1:       v[j] = $urandom;
                    default: v[j] = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF - 32'($urandom_range(0, 3))
                                                                : 32'h80000000 + 32'($urandom_range(0, 3));
                endcase
            end
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            send(v[0], v[1], v[2], ($urandom_range(0, 7) == 0) || (i == 299), sh,
                 1'($urandom_range(0, 1)), 1'b1);
        end

        // Drain
        ready_mode = 1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        idle(2);
        chk("drain_remaining", 80'(exp_q.size()), 80'd0);
        chk("drain_out_valid", 80'(out_valid), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
